// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM feeding a registered ALU; sequences one instruction at a time.
// Define MC_CTRL_PERF_EN to build the cycle and retired-instruction counters.
module mips_mc_control #(
   parameter int OPC_W      = 6,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [OPC_W-1:0]      opcode,
   input  logic [OPC_W-1:0]      funct,
   input  logic                  zero_flag,
   input  logic                  mem_ready,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            pc_src,
   output logic                  pc_write,
   output logic                  tgt_write,
   output logic                  iord,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  mdr_write,
   output logic                  reg_write,
   output logic                  reg_dst,
   output logic                  mem_to_reg,
   output logic                  illegal_op,
   output logic [3:0]            state_o,
   output logic [31:0]           cycle_cnt,
   output logic [31:0]           instr_cnt
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_ADDI_EX = 4'd9,
      S_ADDI_WB = 4'd10,
      S_BR_TGT  = 4'd11,
      S_BR_CMP  = 4'd12,
      S_BR_RES  = 4'd13,
      S_JUMP    = 4'd14
   } state_e;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

   localparam logic [OPC_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OPC_W-1:0] FN_SUB = 6'b100010;
   localparam logic [OPC_W-1:0] FN_AND = 6'b100100;
   localparam logic [OPC_W-1:0] FN_OR  = 6'b100101;
   localparam logic [OPC_W-1:0] FN_SLT = 6'b101010;
   localparam logic [OPC_W-1:0] FN_NOR = 6'b100111;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

   state_e                  state_q, state_d;
   logic                    illegal_q;
   logic                    illegalSet;
   logic                    functOk;
   logic [ALU_CTRL_W-1:0]   functAlu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | illegalSet;
      end
   end

   always_comb begin
      functOk  = 1'b1;
      functAlu = ALU_ADD;
      case (funct)
         FN_ADD:  functAlu = ALU_ADD;
         FN_SUB:  functAlu = ALU_SUB;
         FN_AND:  functAlu = ALU_AND;
         FN_OR:   functAlu = ALU_OR;
         FN_SLT:  functAlu = ALU_SLT;
         FN_NOR:  functAlu = ALU_NOR;
         default: functOk  = 1'b0;
      endcase
   end

   // ALU results land one state after issue, so MEMRD/MEMWR keep re-issuing the address add
   // and BR_RES keeps the SUB so zero_flag stays meaningful.
   always_comb begin
      state_d     = state_q;
      illegalSet  = 1'b0;
      alu_control = ALU_AND;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      pc_write    = 1'b0;
      tgt_write   = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      mdr_write   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read    = 1'b1;
            alu_control = ALU_ADD;
            alu_src_b   = 2'b01;
            ir_write    = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            pc_write = 1'b1;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  if (functOk) begin
                     state_d = S_EXEC;
                  end else begin
                     illegalSet = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               OP_BEQ:  state_d = S_BR_TGT;
               OP_ADDI: state_d = S_ADDI_EX;
               OP_J:    state_d = S_JUMP;
               default: begin
                  illegalSet = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_control = ALU_ADD;
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            alu_control = ALU_ADD;
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            iord        = 1'b1;
            mem_read    = 1'b1;
            mdr_write   = mem_ready;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            alu_control = ALU_ADD;
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            iord        = 1'b1;
            mem_write   = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alu_control = functAlu;
            alu_src_a   = 1'b1;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_ADDI_EX: begin
            alu_control = ALU_ADD;
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            state_d     = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BR_TGT: begin
            alu_control = ALU_ADD;
            alu_src_b   = 2'b11;
            state_d     = S_BR_CMP;
         end
         S_BR_CMP: begin
            alu_control = ALU_SUB;
            alu_src_a   = 1'b1;
            tgt_write   = 1'b1;
            state_d     = S_BR_RES;
         end
         S_BR_RES: begin
            alu_control = ALU_SUB;
            alu_src_a   = 1'b1;
            pc_write    = zero_flag;
            pc_src      = 2'b01;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign illegal_op = illegal_q;
   assign state_o    = state_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycleCnt_q;
   logic [31:0] instrCnt_q;
   logic        retire;

   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_MEMWB, S_ALUWB, S_ADDI_WB, S_BR_RES, S_JUMP: retire = 1'b1;
         S_MEMWR: retire = mem_ready;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycleCnt_q <= 32'd0;
         instrCnt_q <= 32'd0;
      end else begin
         if (state_q != S_IDLE) cycleCnt_q <= cycleCnt_q + 32'd1;
         if (retire)            instrCnt_q <= instrCnt_q + 32'd1;
      end
   end

   assign cycle_cnt = cycleCnt_q;
   assign instr_cnt = instrCnt_q;
`else
   assign cycle_cnt = 32'd0;
   assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: each instruction is expanded into its expected
// per-cycle control bundle from the instruction-class rules; a monitor compares every cycle.
`timescale 1ns/1ps
module tb_mips_mc_control;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_BADOP = 6, K_BADFN = 7;

   typedef struct packed {
      logic [3:0] alu;
      logic       srcA;
      logic [1:0] srcB;
      logic [1:0] pcSrc;
      logic       pcWrite;
      logic       tgtWrite;
      logic       iord;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       mdrWrite;
      logic       regWrite;
      logic       regDst;
      logic       memToReg;
      logic       illegal;
   } ctl_t;

   typedef struct {
      ctl_t       ctl;
      logic       ready;
      logic       zero;
      logic       retires;
      logic       setsIll;
      logic [5:0] opc;
      logic [5:0] fn;
   } plan_t;

   typedef struct {
      ctl_t        ctl;
      logic        idle;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero_flag;
   logic        mem_ready;
   logic [3:0]  alu_control;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  pc_src;
   logic        pc_write, tgt_write, iord, mem_read, mem_write, ir_write, mdr_write;
   logic        reg_write, reg_dst, mem_to_reg, illegal_op;
   logic [3:0]  state_o;
   logic [31:0] cycle_cnt, instr_cnt;

   int          total = 0;
   int          bad = 0;
   plan_t       plan[$];
   exp_t        expQ[$];
   logic        sticky = 1'b0;
   logic [31:0] busy = 32'd0;
   logic [31:0] retired = 32'd0;
   logic [5:0]  planOpc, planFn;
   ctl_t        actCtl;

   mips_mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
      .zero_flag(zero_flag), .mem_ready(mem_ready),
      .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_src(pc_src), .pc_write(pc_write), .tgt_write(tgt_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mdr_write(mdr_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state_o(state_o),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   assign actCtl = {alu_control, alu_src_a, alu_src_b, pc_src, pc_write, tgt_write, iord,
                    mem_read, mem_write, ir_write, mdr_write, reg_write, reg_dst,
                    mem_to_reg, illegal_op};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] aluOf(input logic [5:0] fn);
      case (fn)
         6'h20:   return ALU_ADD;
         6'h22:   return ALU_SUB;
         6'h24:   return ALU_AND;
         6'h25:   return ALU_OR;
         6'h2A:   return ALU_SLT;
         default: return ALU_NOR;
      endcase
   endfunction

   function automatic bit fnSupported(input logic [5:0] fn);
      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
   endfunction

   function automatic bit opSupported(input logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
   endfunction

   task automatic addEntry(input ctl_t c, input logic ready, input logic retires, input logic setsIll);
      plan_t p;
      p.ctl = c; p.ready = ready; p.zero = 1'($urandom);
      p.retires = retires; p.setsIll = setsIll; p.opc = planOpc; p.fn = planFn;
      plan.push_back(p);
   endtask

   // Expands one instruction into the expected control bundle of every cycle it occupies.
   task automatic buildInstr(input int kind, input logic [5:0] opc, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
      ctl_t c;
      bit   bad;
      planOpc = opc;
      planFn  = fn;
      bad = (kind == K_BADOP) || (kind == K_BADFN);
      for (int i = 0; i <= fw; i++) begin
         c = '0; c.alu = ALU_ADD; c.srcB = 2'b01; c.memRead = 1'b1; c.irWrite = (i == fw);
         addEntry(c, i == fw, 1'b0, 1'b0);
      end
      c = '0; c.pcWrite = 1'b1;
      addEntry(c, 1'($urandom), 1'b0, bad);
      case (kind)
         K_R: begin
            c = '0; c.alu = aluOf(fn); c.srcA = 1'b1;
            addEntry(c, 1'($urandom), 1'b0, 1'b0);
            c = '0; c.regWrite = 1'b1; c.regDst = 1'b1;
            addEntry(c, 1'($urandom), 1'b1, 1'b0);
         end
         K_LW, K_SW: begin
            c = '0; c.alu = ALU_ADD; c.srcA = 1'b1; c.srcB = 2'b10;
            addEntry(c, 1'($urandom), 1'b0, 1'b0);
            for (int i = 0; i <= mw; i++) begin
               c = '0; c.alu = ALU_ADD; c.srcA = 1'b1; c.srcB = 2'b10; c.iord = 1'b1;
               if (kind == K_LW) begin
                  c.memRead = 1'b1; c.mdrWrite = (i == mw);
                  addEntry(c, i == mw, 1'b0, 1'b0);
               end else begin
                  c.memWrite = 1'b1;
                  addEntry(c, i == mw, i == mw, 1'b0);
               end
            end
            if (kind == K_LW) begin
               c = '0; c.regWrite = 1'b1; c.memToReg = 1'b1;
               addEntry(c, 1'($urandom), 1'b1, 1'b0);
            end
         end
         K_BEQ: begin
            c = '0; c.alu = ALU_ADD; c.srcB = 2'b11;
            addEntry(c, 1'($urandom), 1'b0, 1'b0);
            c = '0; c.alu = ALU_SUB; c.srcA = 1'b1; c.tgtWrite = 1'b1;
            addEntry(c, 1'($urandom), 1'b0, 1'b0);
            c = '0; c.alu = ALU_SUB; c.srcA = 1'b1; c.pcSrc = 2'b01; c.pcWrite = z;
            addEntry(c, 1'($urandom), 1'b1, 1'b0);
            plan[plan.size()-1].zero = z;
         end
         K_ADDI: begin
            c = '0; c.alu = ALU_ADD; c.srcA = 1'b1; c.srcB = 2'b10;
            addEntry(c, 1'($urandom), 1'b0, 1'b0);
            c = '0; c.regWrite = 1'b1;
            addEntry(c, 1'($urandom), 1'b1, 1'b0);
         end
         K_J: begin
            c = '0; c.pcWrite = 1'b1; c.pcSrc = 2'b10;
            addEntry(c, 1'($urandom), 1'b1, 1'b0);
         end
         default: ;
      endcase
   endtask

   task automatic pushIdle();
      exp_t e;
      mem_ready = 1'($urandom);
      zero_flag = 1'($urandom);
      e.ctl = '0; e.idle = 1'b1; e.cyc = 32'd0; e.ins = 32'd0;
      expQ.push_back(e);
   endtask

   task automatic playPlan(input int n);
      plan_t p;
      exp_t  e;
      for (int i = 0; i < n && plan.size() > 0; i++) begin
         p = plan.pop_front();
         @(negedge clk);
         opcode = p.opc; funct = p.fn; mem_ready = p.ready; zero_flag = p.zero;
         e.ctl = p.ctl; e.ctl.illegal = sticky; e.idle = 1'b0;
`ifdef MC_CTRL_PERF_EN
         e.cyc = busy; e.ins = retired;
`else
         e.cyc = 32'd0; e.ins = 32'd0;
`endif
         expQ.push_back(e);
         busy = busy + 32'd1;
         if (p.retires) retired = retired + 32'd1;
         if (p.setsIll) sticky = 1'b1;
      end
   endtask

   task automatic applyStimulus(input int kind, input logic [5:0] fnIn, input int fw, input int mw, input logic z);
      logic [5:0] op, fn;
      fn = fnIn;
      case (kind)
         K_R:    op = 6'h00;
         K_LW:   op = 6'h23;
         K_SW:   op = 6'h2B;
         K_BEQ:  op = 6'h04;
         K_ADDI: op = 6'h08;
         K_J:    op = 6'h02;
         K_BADFN: op = 6'h00;
         default: begin
            op = 6'($urandom);
            while (opSupported(op)) op = 6'($urandom);
         end
      endcase
      buildInstr(kind, op, fn, fw, mw, z);
      playPlan(plan.size());
   endtask

   task automatic randomInstr();
      int         kind;
      logic [5:0] fn;
      logic [5:0] goodFn[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
      kind = $urandom_range(0, 7);
      fn = 6'($urandom);
      if (kind == K_R) fn = goodFn[$urandom_range(0, 5)];
      if (kind == K_BADFN) while (fnSupported(fn)) fn = 6'($urandom);
      applyStimulus(kind, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
   endtask

   // Monitor: compares the DUT against the oldest queued expectation, mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("ctl", 64'(actCtl), 64'(e.ctl));
            checkOutput("state_idle", 64'(state_o == 4'd0), 64'(e.idle));
            checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
            checkOutput("instr_cnt", 64'(instr_cnt), 64'(e.ins));
         end
      end
   end

   initial begin
      rst_n = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; zero_flag = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state", 64'(state_o), 64'd0);
      checkOutput("reset_illegal", 64'(illegal_op), 64'd0);
      rst_n = 1'b1;
      pushIdle();

      applyStimulus(K_R, 6'h20, 0, 0, 1'b0);
      applyStimulus(K_LW, 6'h00, 0, 0, 1'b0);
      applyStimulus(K_J, 6'h00, 0, 0, 1'b0);
      applyStimulus(K_LW, 6'h11, 1, 3, 1'b0);
      applyStimulus(K_BEQ, 6'h00, 0, 0, 1'b1);
      applyStimulus(K_BEQ, 6'h00, 0, 0, 1'b0);
      planOpc = 6'h3F;
      buildInstr(K_BADOP, 6'h3F, 6'h20, 0, 0, 1'b0);
      playPlan(plan.size());
      applyStimulus(K_BADFN, 6'h03, 0, 0, 1'b0);
      applyStimulus(K_ADDI, 6'h00, 2, 0, 1'b0);

      for (int i = 0; i < 60; i++) randomInstr();

      // sw stalled in MEMWR, then an asynchronous reset between clock edges.
      buildInstr(K_SW, 6'h2B, 6'h00, 0, 5, 1'b0);
      playPlan(5);
      plan.delete();
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_mem_write", 64'(mem_write), 64'd0);
      checkOutput("rst_mem_read", 64'(mem_read), 64'd0);
      checkOutput("rst_state", 64'(state_o), 64'd0);
      checkOutput("rst_illegal", 64'(illegal_op), 64'd0);
      checkOutput("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sticky = 1'b0; busy = 32'd0; retired = 32'd0;
      pushIdle();

      for (int i = 0; i < 20; i++) randomInstr();

      @(negedge clk);
      #2;
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Multicycle MIPS control FSM that sits directly upstream of the registered signed ALU.
- Decodes the latched instruction (opcode/funct) and drives alu_control, operand selects, memory, PC and register-file enables for one instruction at a time.
- Sequencing accounts for the ALU's one-cycle registered latency: alu_out and zero_flag are consumed one state after the operation is issued.

Parameters:
OPC_W, 6, opcode/funct field width
ALU_CTRL_W, 4, alu_control width (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero_flag  in  1  registered ALU zero flag (valid only the cycle after a SUB)
mem_ready  in  1  memory handshake: current read/write completes this cycle
alu_control  out  4  ALU operation
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
pc_src  out  2  00 = alu_out, 01 = branch target reg, 10 = jump address
pc_write  out  1  PC load enable
tgt_write  out  1  branch target register load (captures alu_out)
iord  out  1  memory address: 0 = PC, 1 = alu_out
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mdr_write  out  1  memory data register load
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = alu_out, 1 = MDR
illegal_op  out  1  sticky: unsupported opcode or funct seen
state_o  out  4  current state encoding (debug)
cycle_cnt  out  32  performance cycle counter (see Optional Feature)
instr_cnt  out  32  retired-instruction counter (see Optional Feature)

Behaviour:
- Outputs are combinational decodes of the state register (plus mem_ready/zero_flag where noted). Any output not listed for a state is 0; alu_control defaults to 0000.
- Reset (async): state = IDLE, illegal_op = 0. All outputs are 0 while in IDLE. IDLE -> FETCH on the next clock. Reset mid-instruction aborts it immediately; mem_write and mem_read drop with no clock edge required.
- FETCH: mem_read=1, iord=0, ADD, src_a=0, src_b=01. Holds until mem_ready; ir_write = mem_ready. -> DECODE on mem_ready.
- DECODE: pc_write=1, pc_src=00 (alu_out = PC+4). Dispatch:
  - 100011/101011 -> MEMADR
  - 000000 with supported funct -> EXEC
  - 000100 -> BR_TGT
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - anything else -> set illegal_op, -> FETCH
- Supported funct values: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
- MEMADR: ADD, src_a=1, src_b=10. -> MEMRD (lw) or MEMWR (sw).
- MEMRD: ADD, src_a=1, src_b=10 held so alu_out stays stable. iord=1, mem_read=1, mdr_write = mem_ready. -> MEMWB on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEMWR: same ALU hold as MEMRD. iord=1, mem_write=1 held until mem_ready. -> FETCH on mem_ready.
- EXEC: alu_control from funct, src_a=1, src_b=00. -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- ADDI_EX: ADD, src_a=1, src_b=10. -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- BR_TGT: ADD, src_a=0 (PC already = PC+4), src_b=11. -> BR_CMP.
- BR_CMP: SUB, src_a=1, src_b=00; tgt_write=1 (alu_out = target). -> BR_RES.
- BR_RES: SUB held; pc_write = zero_flag, pc_src=01. -> FETCH.
- JUMP: pc_write=1, pc_src=10. -> FETCH.
- Latency with mem_ready held high: R-type/addi 4 cycles, lw 5, sw 4, beq 5, j 3.
- Handshake rules:
  - Memory requests stay asserted until mem_ready; mem_ready outside FETCH/MEMRD/MEMWR is ignored.
  - Exactly one of mem_read/mem_write is active at a time.
- illegal_op clears only on reset. Illegal instructions cause no reg_write and no mem_write.

Optional Feature:
MC_CTRL_PERF_EN
- Defined:
  - cycle_cnt increments every cycle outside IDLE.
  - instr_cnt increments once per retirement: the cycle leaving MEMWB, MEMWR, ALUWB, ADDI_WB, BR_RES or JUMP. Illegal instructions do not retire.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: cycle_cnt and instr_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then opcode=0, funct=0x20, mem_ready=1 -> IDLE, FETCH, DECODE, EXEC (alu_control=0010, src_a=1, src_b=00), ALUWB (reg_write=1, reg_dst=1), FETCH.
- lw (0x23), mem_ready low 3 cycles in MEMRD -> mem_read/iord held 4 cycles, mdr_write only in the ready cycle, then MEMWB with mem_to_reg=1.
- beq (0x04), zero_flag=1 in BR_RES -> tgt_write in BR_CMP, pc_write=1, pc_src=01. Repeat with zero_flag=0 -> pc_write=0, back to FETCH.
- opcode=0x3F, then opcode=0 with funct=0x03 -> illegal_op=1 after the first DECODE and stays 1. No reg_write/mem_write. Next FETCH is entered normally.
- sw (0x2B), rst_n pulled low mid-MEMWR with mem_ready=0 -> mem_write=0 immediately, state_o=IDLE, illegal_op=0, FETCH one cycle after release.
- With MC_CTRL_PERF_EN, run add, lw, j back to back (mem_ready=1) -> instr_cnt=3, cycle_cnt=12 when FETCH of the 4th instruction is entered.
